clock_settings_fsm: RTL

User-input front end for the alarm clock. It turns two raw push-buttons into a set-time / set-alarm editing state machine. It captures the running time from the minute and hour counters, lets the user step hours and minutes, and commits results with single-cycle load pulses. Its outputs drive the time counters' load inputs and the alarm module's `set_alarm` / `set_minutes` / `set_hours` inputs.

---
 rtl/clock_pkg.sv | 27 ++
 rtl/button_debounce.sv | 53 +++++
 rtl/clock_settings_fsm.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the alarm clock: time widths, wrap limits and the
// settings FSM state encoding, plus wrap-around increment helpers.
package clock_pkg;

    localparam int unsigned MIN_W  = 7;
    localparam int unsigned HOUR_W = 6;

    localparam logic [MIN_W-1:0]  MIN_MAX  = 7'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 6'd23;

    typedef enum logic [2:0] {
        StRun     = 3'd0,
        StEditHr  = 3'd1,
        StEditMin = 3'd2,
        StAlmHr   = 3'd3,
        StAlmMin  = 3'd4
    } set_state_t;

    function automatic logic [MIN_W-1:0] next_minute(input logic [MIN_W-1:0] m);
        return (m >= MIN_MAX) ? '0 : m + 7'd1;
    endfunction

    function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
        return (h >= HOUR_MAX) ? '0 : h + 6'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press event on the accepted released-to-pressed transition.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_evt_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            evt_q, evt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Level is active-low: 1 = released.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = sync2_q;
            evt_d   = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            evt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_evt_o = evt_q;

endmodule

// File: rtl/clock_settings_fsm.sv
// Set-time / set-alarm editing front end: two debounced buttons drive an edit FSM
// that captures the running time, steps hours/minutes and commits with load pulses.
module clock_settings_fsm
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TIMEOUT_CYCLES  = 500000000,
    parameter int unsigned BLINK_CYCLES    = 12500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [MIN_W-1:0]  cur_minutes,
    input  logic [HOUR_W-1:0] cur_hours,
    output logic              load_time,
    output logic [MIN_W-1:0]  load_minutes,
    output logic [HOUR_W-1:0] load_hours,
    output logic              set_alarm,
    output logic [MIN_W-1:0]  set_minutes,
    output logic [HOUR_W-1:0] set_hours,
    output logic [2:0]        mode,
    output logic [MIN_W-1:0]  edit_value_min,
    output logic [HOUR_W-1:0] edit_value_hr,
    output logic              blink
);

    localparam int unsigned IdleW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BlinkW = $clog2(BLINK_CYCLES + 1);

    logic mode_evt, inc_evt;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk        (clk),
        .rst        (rst),
        .btn_i      (btn_mode),
        .press_evt_o(mode_evt)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_btn (
        .clk        (clk),
        .rst        (rst),
        .btn_i      (btn_inc),
        .press_evt_o(inc_evt)
    );

    set_state_t        state_q, state_d;
    logic [HOUR_W-1:0] work_hr_q, work_hr_d, load_hr_q, load_hr_d, alarm_hr_q, alarm_hr_d;
    logic [MIN_W-1:0]  work_min_q, work_min_d, load_min_q, load_min_d, alarm_min_q, alarm_min_d;
    logic              load_time_q, load_time_d, set_alarm_q, set_alarm_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic              blink_q, blink_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              in_edit, timeout, inc_take;

    always_comb begin
        state_d     = state_q;
        work_hr_d   = work_hr_q;
        work_min_d  = work_min_q;
        load_hr_d   = load_hr_q;
        load_min_d  = load_min_q;
        alarm_hr_d  = alarm_hr_q;
        alarm_min_d = alarm_min_q;
        load_time_d = 1'b0;
        set_alarm_d = 1'b0;
        idle_d      = idle_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;

        in_edit  = (state_q != StRun);
        timeout  = in_edit && (idle_q == IdleW'(TIMEOUT_CYCLES - 1));
        inc_take = in_edit && inc_evt && !mode_evt;

        unique case (state_q)
            StRun: begin
                if (mode_evt) begin
                    state_d    = StEditHr;
                    work_hr_d  = cur_hours;
                    work_min_d = cur_minutes;
                end
            end
            StEditHr: begin
                if (mode_evt)     state_d   = StEditMin;
                else if (inc_evt) work_hr_d = next_hour(work_hr_q);
            end
            StEditMin: begin
                if (mode_evt) begin
                    state_d     = StAlmHr;
                    load_time_d = 1'b1;
                    load_hr_d   = work_hr_q;
                    load_min_d  = work_min_q;
                    work_hr_d   = alarm_hr_q;
                    work_min_d  = alarm_min_q;
                end else if (inc_evt) begin
                    work_min_d = next_minute(work_min_q);
                end
            end
            StAlmHr: begin
                if (mode_evt)     state_d   = StAlmMin;
                else if (inc_evt) work_hr_d = next_hour(work_hr_q);
            end
            StAlmMin: begin
                if (mode_evt) begin
                    state_d     = StRun;
                    set_alarm_d = 1'b1;
                    alarm_hr_d  = work_hr_q;
                    alarm_min_d = work_min_q;
                end else if (inc_evt) begin
                    work_min_d = next_minute(work_min_q);
                end
            end
            default: state_d = StRun;
        endcase

        // Any button event counts as activity and defers the timeout.
        if (timeout && !mode_evt && !inc_evt) state_d = StRun;

        if (!in_edit || mode_evt || inc_evt || timeout) idle_d = '0;
        else                                            idle_d = idle_q + IdleW'(1);

        // An increment restarts the half-period with the field lit.
        if (state_d == StRun) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (inc_take) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BlinkW'(BLINK_CYCLES - 1)) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            work_hr_q   <= '0;
            work_min_q  <= '0;
            load_hr_q   <= '0;
            load_min_q  <= '0;
            alarm_hr_q  <= '0;
            alarm_min_q <= '0;
            load_time_q <= 1'b0;
            set_alarm_q <= 1'b0;
            idle_q      <= '0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            work_hr_q   <= work_hr_d;
            work_min_q  <= work_min_d;
            load_hr_q   <= load_hr_d;
            load_min_q  <= load_min_d;
            alarm_hr_q  <= alarm_hr_d;
            alarm_min_q <= alarm_min_d;
            load_time_q <= load_time_d;
            set_alarm_q <= set_alarm_d;
            idle_q      <= idle_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign load_time      = load_time_q;
    assign load_minutes   = load_min_q;
    assign load_hours     = load_hr_q;
    assign set_alarm      = set_alarm_q;
    assign set_minutes    = alarm_min_q;
    assign set_hours      = alarm_hr_q;
    assign mode           = state_q;
    assign edit_value_min = work_min_q;
    assign edit_value_hr  = work_hr_q;
    assign blink          = blink_q;

endmodule
